i2c_slave_regif: RTL
====================

I2C_SLAVE_REGIF -- requirements
Module: i2c_slave_regif

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h55, 7-bit bus address answered.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth for SCL/SDA.
REQ-003 SHALL have port CLOCK_IN  input  1  single system clock (40 MHz nominal, >=16x SCL rate).
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port SCL  input  1  bus clock from the master.
REQ-006 SHALL have port SDA  inout  1  bus data; driven only to 0, otherwise 1'bZ.
REQ-007 SHALL have port WR_EN  output  1  one-clock write strobe.
REQ-008 SHALL have port WR_ADDR  output  8  register address for WR_EN.
REQ-009 SHALL have port WR_DATA  output  8  register data for WR_EN.
REQ-010 SHALL have port RD_ADDR  output  8  current register pointer.
REQ-011 SHALL have port RD_DATA  input  8  combinational register contents at RD_ADDR.
REQ-012 SHALL have port BUSY  output  1  high from addressed START until STOP/mismatch.

Function
REQ-013 SHALL sample SCL and SDA through SYNC_STAGES flops; all edges detected on synchronised values.
REQ-014 SHALL detect START as SDA 1->0 while SCL high, STOP as SDA 0->1 while SCL high; each takes priority over any state.
REQ-015 SHALL implement states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-016 SHALL enter ADDR from any state on START (including repeated START); bit counter cleared.
REQ-017 SHALL shift bits MSB first on SCL rising edges; byte complete after 8th rise.
REQ-018 SHALL, on address match, pull SDA low from the SCL falling edge after bit 8 until the next SCL falling edge (ACK); on mismatch, return to IDLE and never drive SDA.
REQ-019 SHALL, after ACK of address with R/W=0, receive one pointer byte (PTR, ACK) then zero or more data bytes (WDATA, ACK each).
REQ-020 SHALL assert WR_EN for exactly one clock at the SCL rising edge that completes a data byte, with WR_ADDR=pointer, WR_DATA=byte.
REQ-021 SHALL increment the pointer after each write and after each read byte; 8'hFF wraps to 8'h00.
REQ-022 SHALL, with R/W=1, shift RD_DATA (latched at the SCL falling edge ending the ACK) MSB first, changing SDA only while SCL low, releasing for master ACK bit.
REQ-023 SHALL continue reading on master ACK (SDA=0); on NACK, release SDA and wait for STOP/START in IDLE.
REQ-024 SHALL abort an incomplete byte on STOP without WR_EN and return to IDLE.
REQ-025 SHALL not hold SCL low (no clock stretching).
REQ-026 SHALL drive BUSY high from address ACK until STOP, mismatch, or NACK.

Reset
REQ-027 SHALL, while RESET high, force state IDLE, SDA released, WR_EN=0, WR_ADDR=0, WR_DATA=0, RD_ADDR=0, BUSY=0, synchronisers to 1.
REQ-028 SHALL, after reset deasserts mid-transfer, ignore the bus until the next START.

Structure
REQ-029 SHALL place state encodings and the R/W bit constants in shared package i2c_defs, reused by i2c_master.
REQ-030 SHALL use one sub-module, i2c_bus_monitor, for synchronisation and START/STOP/SCL-edge detection.

Verification
REQ-031 SHALL cover: master writes 0xAA,0x84,0x04,STOP -> three ACKs, one WR_EN with WR_ADDR=0x84, WR_DATA=0x04.
REQ-032 SHALL cover: address byte 0xAC (addr 0x56) -> SDA never driven, no WR_EN, BUSY stays 0.
REQ-033 SHALL cover: write 0xAA,0xFF,0x11,0x22 -> WR_EN at 0xFF=0x11 then 0x00=0x22 (wrap).
REQ-034 SHALL cover: 0xAA,0x05, repeated START, 0xAB, read two bytes ACK then NACK -> SDA shows RD_DATA for 0x05 then 0x06; SDA released after NACK.
REQ-035 SHALL cover: STOP after 4 data bits -> no WR_EN, state IDLE, next transfer ACKed normally.
REQ-036 SHALL cover: RESET pulsed during WDATA -> SDA released immediately, outputs at reset values, next START accepted.

Source files
------------

// File: rtl/i2c_defs.sv
`default_nettype none
// ============================================================================
// Module      : i2c_defs (package)
// Description : Shared I2C state encodings and R/W bit constants.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_defs;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8
    } i2c_state_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam logic [3:0] BITS_PER_BYTE = 4'd8;

endpackage : i2c_defs
`default_nettype wire

// File: rtl/i2c_bus_monitor.sv
`default_nettype none
// ============================================================================
// Module      : i2c_bus_monitor
// Description : SCL/SDA synchroniser with START/STOP and SCL edge detection.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_monitor #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;

    // Flops reset to the idle-bus level so reset release never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= (scl_sync << 1) | SYNC_STAGES'(scl);
            sda_sync <= (sda_sync << 1) | SYNC_STAGES'(sda);
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise =  scl_s & ~scl_d;
    assign scl_fall = ~scl_s &  scl_d;
    assign start    =  scl_s &  scl_d &  sda_d & ~sda_s;
    assign stop     =  scl_s &  scl_d & ~sda_d &  sda_s;

endmodule : i2c_bus_monitor
`default_nettype wire

// File: rtl/i2c_slave_regif.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_regif
// Description : I2C slave with 8-bit register pointer and register-file port.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_regif
    import i2c_defs::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h55,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       CLOCK_IN,
    input  logic       RESET,
    input  logic       SCL,
    inout  wire        SDA,
    output logic       WR_EN,
    output logic [7:0] WR_ADDR,
    output logic [7:0] WR_DATA,
    output logic [7:0] RD_ADDR,
    input  logic [7:0] RD_DATA,
    output logic       BUSY
);

    i2c_state_t state;
    i2c_state_t state_nxt;

    logic       sda_s;
    logic       scl_rise;
    logic       scl_fall;
    logic       start;
    logic       stop;
    logic [3:0] bit_cnt;
    logic [6:0] shreg;
    logic [6:0] tx;
    logic [7:0] ptr;
    logic       rw;
    logic       sda_drive;
    logic [7:0] rx_byte;
    logic       shift_en;
    logic       byte_done;
    logic       ack_fall;
    logic       addr_ok;

    i2c_bus_monitor #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_mon (
        .clk      (CLOCK_IN),
        .rst      (RESET),
        .scl      (SCL),
        .sda      (SDA),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    always_ff @(posedge CLOCK_IN or posedge RESET) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_ADDR;
        end else if (stop) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_ADDR: begin
                    if (byte_done && !addr_ok) state_nxt = ST_IDLE;
                    else if (ack_fall)         state_nxt = ST_ADDR_ACK;
                end
                ST_ADDR_ACK:  if (scl_fall) state_nxt = (rw == RW_READ) ? ST_RDATA : ST_PTR;
                ST_PTR:       if (ack_fall) state_nxt = ST_PTR_ACK;
                ST_PTR_ACK:   if (scl_fall) state_nxt = ST_WDATA;
                ST_WDATA:     if (ack_fall) state_nxt = ST_WDATA_ACK;
                ST_WDATA_ACK: if (scl_fall) state_nxt = ST_WDATA;
                ST_RDATA:     if (ack_fall) state_nxt = ST_RDATA_ACK;
                ST_RDATA_ACK: begin
                    if (scl_rise && sda_s) state_nxt = ST_IDLE;
                    else if (scl_fall)     state_nxt = ST_RDATA;
                end
                default:      state_nxt = state;
            endcase
        end
    end

    always_comb begin
        rx_byte   = {shreg, sda_s};
        addr_ok   = (rx_byte[7:1] == SLAVE_ADDR);
        shift_en  = scl_rise && (bit_cnt != BITS_PER_BYTE) &&
                    (state inside {ST_ADDR, ST_PTR, ST_WDATA, ST_RDATA});
        byte_done = shift_en && (bit_cnt == BITS_PER_BYTE - 4'd1);
        ack_fall  = scl_fall && (bit_cnt == BITS_PER_BYTE);
    end

    always_ff @(posedge CLOCK_IN or posedge RESET) begin
        if (RESET) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            tx        <= '0;
            ptr       <= '0;
            rw        <= RW_WRITE;
            sda_drive <= 1'b0;
            WR_EN     <= 1'b0;
            WR_ADDR   <= '0;
            WR_DATA   <= '0;
            BUSY      <= 1'b0;
        end else begin
            WR_EN <= 1'b0;
            if (start) begin
                bit_cnt   <= '0;
                sda_drive <= 1'b0;
            end else if (stop) begin
                bit_cnt   <= '0;
                sda_drive <= 1'b0;
                BUSY      <= 1'b0;
            end else begin
                if (shift_en) begin
                    shreg   <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 4'd1;
                end
                case (state)
                    ST_ADDR: begin
                        if (byte_done) begin
                            rw <= rx_byte[0];
                            if (!addr_ok) BUSY <= 1'b0;
                        end
                        if (ack_fall) begin
                            sda_drive <= 1'b1;
                            BUSY      <= 1'b1;
                        end
                    end
                    ST_PTR: begin
                        if (byte_done) ptr <= rx_byte;
                        if (ack_fall)  sda_drive <= 1'b1;
                    end
                    ST_WDATA: begin
                        if (byte_done) begin
                            WR_EN   <= 1'b1;
                            WR_ADDR <= ptr;
                            WR_DATA <= rx_byte;
                            ptr     <= ptr + 8'd1;
                        end
                        if (ack_fall) sda_drive <= 1'b1;
                    end
                    ST_RDATA: begin
                        if (ack_fall) begin
                            sda_drive <= 1'b0;
                            ptr       <= ptr + 8'd1;
                        end else if (scl_fall) begin
                            sda_drive <= ~tx[6];
                            tx        <= {tx[5:0], 1'b0};
                        end
                    end
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK, ST_RDATA_ACK: begin
                        if (state == ST_RDATA_ACK && scl_rise && sda_s) BUSY <= 1'b0;
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            // Read data is latched as the ACK slot closes; MSB goes out immediately.
                            if ((state == ST_ADDR_ACK && rw == RW_READ) || state == ST_RDATA_ACK) begin
                                tx        <= RD_DATA[6:0];
                                sda_drive <= ~RD_DATA[7];
                            end else begin
                                sda_drive <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign SDA     = sda_drive ? 1'b0 : 1'bz;
    assign RD_ADDR = ptr;

endmodule : i2c_slave_regif
`default_nettype wire
